// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared gear/speed definitions for the drive state controller and display blocks
//
// Purpose: gear limits, speed width, FSM state encoding, the gear->max_level lookup
//          and the speed_value packing used by the speed FND path.
// Ports:   none (package).
package drive_pkg;

  localparam int         SPEED_W  = 4;
  localparam logic [2:0] GEAR_MIN = 3'd1;
  localparam logic [2:0] GEAR_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_COAST = 2'd0,
    ST_ACCEL = 2'd1,
    ST_BRAKE = 2'd2
  } drive_state_e;

  // Highest speed level reachable in each gear; out-of-range gears map to gear 1.
  function automatic logic [SPEED_W-1:0] max_lv(input logic [2:0] gear);
    case (gear)
      3'd2:    return 4'd3;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [31:0] pack_speed(input logic [SPEED_W-1:0] speed,
                                             input logic [SPEED_W-1:0] max_level);
    return {24'd0, max_level, speed};
  endfunction

endpackage

// File: rtl/drive_state_controller_if.sv
// rtl/drive_state_controller_if.sv - driver button inputs and speed/gear outputs of the drive controller
//
// Purpose: bundles the button levels and the registered speed/gear results.
// Signals: btn_accel, btn_brake, btn_gear_up, btn_gear_dn (levels, driven by master)
//          speed_value[31:0] = {24'd0, max_level, speed}, gear[2:0] (driven by slave)
// Modports: master = button source / display side, slave = drive_state_controller.
interface drive_state_controller_if;

  logic        btn_accel;
  logic        btn_brake;
  logic        btn_gear_up;
  logic        btn_gear_dn;
  logic [31:0] speed_value;
  logic [2:0]  gear;

  modport master (
    output btn_accel, btn_brake, btn_gear_up, btn_gear_dn,
    input  speed_value, gear
  );

  modport slave (
    input  btn_accel, btn_brake, btn_gear_up, btn_gear_dn,
    output speed_value, gear
  );

endinterface

// File: rtl/btn_rise_detect.sv
// rtl/btn_rise_detect.sv - single-cycle pulse on the rising edge of a button level
//
// Purpose: one history register; pulse_o = btn_i & ~history.
// Ports:   clk_i (clock), rst_i (sync active-high reset, history cleared),
//          btn_i (button level), pulse_o (combinational rising-edge pulse)
module btn_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= btn_i;
    end
  end

  assign pulse_o = btn_i & ~hist_q;

endmodule

// File: rtl/drive_state_controller.sv
// rtl/drive_state_controller.sv - turns accel/brake/gear buttons into speed level, max level and gear
//
// Purpose: ACCEL/BRAKE/COAST FSM recomputed each cycle from the pedals; a step counter
//          applies +/-1 speed steps, gear buttons act on rising edges, downshifts clamp speed.
// Config:  define DRIVE_AUTO_SHIFT_EN to upshift automatically when saturated in ACCEL.
// Params:  STEP_CYCLES  cycles per step while a pedal is held (>=1)
//          COAST_CYCLES cycles per -1 step while coasting (>=1)
// Ports:   clk (clock), rst (sync active-high reset)
//          bus (slave): btn_* in, speed_value {24'd0, max_level, speed} out, gear out
module drive_state_controller #(
  parameter logic [15:0] STEP_CYCLES  = 16'd4,
  parameter logic [15:0] COAST_CYCLES = 16'd8
) (
  input  logic                    clk,
  input  logic                    rst,
  drive_state_controller_if.slave bus
);

  import drive_pkg::*;

  drive_state_e        state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, cnt_lim;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [SPEED_W-1:0]  max_cur, max_dn;
  logic [2:0]          gear_q, gear_d;
  logic                up_p, dn_p;
  logic                step, man_up, man_dn, auto_up;

  btn_rise_detect u_up_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (bus.btn_gear_up),
    .pulse_o (up_p)
  );

  btn_rise_detect u_dn_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (bus.btn_gear_dn),
    .pulse_o (dn_p)
  );

  assign max_cur = max_lv(gear_q);
  assign max_dn  = max_lv(gear_q - 3'd1);

  always_comb begin
    state_d = ST_COAST;
    cnt_d   = cnt_q + 16'd1;
    step    = 1'b0;
    gear_d  = gear_q;
    speed_d = speed_q;

    if (bus.btn_brake) begin
      state_d = ST_BRAKE;
    end else if (bus.btn_accel) begin
      state_d = ST_ACCEL;
    end

    cnt_lim = (state_q == ST_COAST) ? (COAST_CYCLES - 16'd1) : (STEP_CYCLES - 16'd1);

    // Entering a new state restarts the step period on that same edge.
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q >= cnt_lim) begin
      cnt_d = 16'd0;
      step  = 1'b1;
    end

    // Simultaneous up and down edges cancel each other.
    man_up = up_p & ~dn_p & (gear_q < GEAR_MAX);
    man_dn = dn_p & ~up_p & (gear_q > GEAR_MIN);

`ifdef DRIVE_AUTO_SHIFT_EN
    // Any manual edge this cycle suppresses the automatic upshift.
    auto_up = step & (state_q == ST_ACCEL) & (speed_q == max_cur) &
              (gear_q < GEAR_MAX) & ~up_p & ~dn_p;
`else
    auto_up = 1'b0;
`endif

    if (man_up || auto_up) begin
      gear_d = gear_q + 3'd1;
    end else if (man_dn) begin
      gear_d = gear_q - 3'd1;
    end

    if (step) begin
      if (state_q == ST_ACCEL) begin
        if (speed_q < max_cur) speed_d = speed_q + 4'd1;
      end else if (speed_q != 4'd0) begin
        speed_d = speed_q - 4'd1;
      end
    end

    // Clamp after the step so a coinciding accel step cannot exceed the new ceiling.
    if (man_dn && (speed_d > max_dn)) begin
      speed_d = max_dn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COAST;
      cnt_q   <= 16'd0;
      speed_q <= '0;
      gear_q  <= GEAR_MIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      gear_q  <= gear_d;
    end
  end

  assign bus.speed_value = pack_speed(speed_q, max_cur);
  assign bus.gear        = gear_q;

endmodule

// File: tb/tb_drive_state_controller.sv
// tb/tb_drive_state_controller.sv - directed vector bench for drive_state_controller
module tb_drive_state_controller;

  typedef struct {
    logic        a;
    logic        b;
    logic        u;
    logic        d;
    int          n;
    logic [31:0] sv;
    logic [2:0]  g;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vt[$];

  drive_state_controller_if bus ();

  drive_state_controller #(
    .STEP_CYCLES  (16'd4),
    .COAST_CYCLES (16'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic a, logic b, logic u, logic d, int n,
                              logic [31:0] sv, logic [2:0] g);
    vec_t v;
    v.a = a; v.b = b; v.u = u; v.d = d; v.n = n; v.sv = sv; v.g = g;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(logic a, logic b, logic u, logic d);
    bus.btn_accel   = a;
    bus.btn_brake   = b;
    bus.btn_gear_up = u;
    bus.btn_gear_dn = d;
  endtask

  task automatic check(string nm, logic [31:0] sv_exp, logic [2:0] g_exp);
    checks++;
    if (bus.speed_value !== sv_exp) begin
      errors++;
      $display("FAIL %s speed_value: got %h expected %h", nm, bus.speed_value, sv_exp);
    end
    checks++;
    if (bus.gear !== g_exp) begin
      errors++;
      $display("FAIL %s gear: got %0d expected %0d", nm, bus.gear, g_exp);
    end
  endtask

  initial begin
    logic [3:0] auto_spd[1:14];
    logic [2:0] auto_gear[1:14];
    logic [3:0] mx;

    set_btn(0, 0, 0, 0);

    // idle, three upshifts, accel ramp to saturation, clamping downshift
    vt.push_back(mk(0,0,0,0, 8, 32'h10, 3'd1));
    vt.push_back(mk(0,0,1,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,0,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,1,0, 1, 32'h50, 3'd3));
    vt.push_back(mk(0,0,0,0, 1, 32'h50, 3'd3));
    vt.push_back(mk(0,0,1,0, 1, 32'h70, 3'd4));
    vt.push_back(mk(0,0,0,0, 1, 32'h70, 3'd4));
    vt.push_back(mk(1,0,0,0, 4, 32'h70, 3'd4));
    vt.push_back(mk(1,0,0,0, 1, 32'h71, 3'd4));
    vt.push_back(mk(1,0,0,0, 3, 32'h71, 3'd4));
    vt.push_back(mk(1,0,0,0, 1, 32'h72, 3'd4));
    vt.push_back(mk(1,0,0,0,20, 32'h77, 3'd4));
    vt.push_back(mk(1,0,0,0,12, 32'h77, 3'd4));
    vt.push_back(mk(0,0,0,1, 1, 32'h55, 3'd3));
    // both pedals = brake, coast from 3, brake down to floor
    vt.push_back(mk(1,1,0,0, 4, 32'h55, 3'd3));
    vt.push_back(mk(1,1,0,0, 1, 32'h54, 3'd3));
    vt.push_back(mk(1,1,0,0, 4, 32'h53, 3'd3));
    vt.push_back(mk(0,0,0,0, 8, 32'h53, 3'd3));
    vt.push_back(mk(0,0,0,0, 1, 32'h52, 3'd3));
    vt.push_back(mk(1,1,0,0, 4, 32'h52, 3'd3));
    vt.push_back(mk(1,1,0,0, 1, 32'h51, 3'd3));
    vt.push_back(mk(1,1,0,0, 4, 32'h50, 3'd3));
    vt.push_back(mk(1,1,0,0,12, 32'h50, 3'd3));
    // gear bounds
    vt.push_back(mk(0,0,1,0, 1, 32'h70, 3'd4));
    vt.push_back(mk(0,0,0,0, 1, 32'h70, 3'd4));
    vt.push_back(mk(0,0,1,0, 1, 32'h90, 3'd5));
    vt.push_back(mk(0,0,0,0, 1, 32'h90, 3'd5));
    vt.push_back(mk(0,0,1,0, 1, 32'h90, 3'd5));
    vt.push_back(mk(0,0,0,0, 1, 32'h90, 3'd5));
    vt.push_back(mk(0,0,0,1, 1, 32'h70, 3'd4));
    vt.push_back(mk(0,0,0,0, 1, 32'h70, 3'd4));
    vt.push_back(mk(0,0,0,1, 1, 32'h50, 3'd3));
    vt.push_back(mk(0,0,0,0, 1, 32'h50, 3'd3));
    vt.push_back(mk(0,0,0,1, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,0,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,0,1, 1, 32'h10, 3'd1));
    vt.push_back(mk(0,0,0,0, 1, 32'h10, 3'd1));
    vt.push_back(mk(0,0,0,1, 1, 32'h10, 3'd1));
    vt.push_back(mk(0,0,0,0, 1, 32'h10, 3'd1));
    vt.push_back(mk(0,0,1,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,0,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,1,1, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,0,0, 1, 32'h30, 3'd2));
    vt.push_back(mk(0,0,1,0, 3, 32'h50, 3'd3));
    vt.push_back(mk(0,0,0,0, 1, 32'h50, 3'd3));
    // downshift coinciding with an accel step: ceiling of the new gear wins
    vt.push_back(mk(1,0,0,0,13, 32'h53, 3'd3));
    vt.push_back(mk(1,0,0,0, 3, 32'h53, 3'd3));
    vt.push_back(mk(1,0,0,1, 1, 32'h33, 3'd2));

    repeat (3) tick();
    check("reset_hold", 32'h10, 3'd1);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      set_btn(vt[i].a, vt[i].b, vt[i].u, vt[i].d);
      repeat (vt[i].n) tick();
      check($sformatf("vec%0d", i), vt[i].sv, vt[i].g);
    end

    // reset in the middle of an accel ramp
    set_btn(1, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("reset_mid_ramp", 32'h10, 3'd1);
    rst = 1'b0;

`ifdef DRIVE_AUTO_SHIFT_EN
    auto_spd  = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd9, 4'd9};
    auto_gear = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5};
`else
    for (int j = 1; j <= 14; j++) begin
      auto_spd[j]  = 4'd1;
      auto_gear[j] = 3'd1;
    end
`endif

    // accel held from gear 1: one check per due step
    for (int j = 1; j <= 14; j++) begin
      repeat ((j == 1) ? 5 : 4) tick();
      case (auto_gear[j])
        3'd2:    mx = 4'd3;
        3'd3:    mx = 4'd5;
        3'd4:    mx = 4'd7;
        3'd5:    mx = 4'd9;
        default: mx = 4'd1;
      endcase
      check($sformatf("auto_step%0d", j), {24'd0, mx, auto_spd[j]}, auto_gear[j]);
    end

    set_btn(0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
